// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit of the single-bus CPU:
// opcode values, ALU operation codes, IR field positions, the sequencer state
// encoding and the instruction classes produced by the opcode decoder.
// No ports (package).
package cpu_ctrl_pkg;

    // Opcodes, IR[31:27]
    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_LDI  = 5'b00001;
    localparam logic [4:0] OPC_ST   = 5'b00010;
    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_SHR  = 5'b00111;
    localparam logic [4:0] OPC_SHL  = 5'b01000;
    localparam logic [4:0] OPC_ADDI = 5'b01100;
    localparam logic [4:0] OPC_ANDI = 5'b01101;
    localparam logic [4:0] OPC_ORI  = 5'b01110;
    localparam logic [4:0] OPC_BR   = 5'b10010;
    localparam logic [4:0] OPC_JR   = 5'b10011;
    localparam logic [4:0] OPC_NOP  = 5'b11010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    // ALU operation codes driven on 'operation'
    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = 5'b00011;
    localparam logic [4:0] ALU_AND  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;

    // IR field positions
    localparam int IR_OPC_HI = 31;
    localparam int IR_OPC_LO = 27;
    localparam int IR_RA_HI  = 26;
    localparam int IR_RA_LO  = 23;
    localparam int IR_RB_HI  = 22;
    localparam int IR_RB_LO  = 19;
    localparam int IR_RC_HI  = 18;
    localparam int IR_RC_LO  = 15;

    typedef enum logic [3:0] {
        RESET_ST = 4'd0,
        T0       = 4'd1,
        T1       = 4'd2,
        T2       = 4'd3,
        T3       = 4'd4,
        T4       = 4'd5,
        T5       = 4'd6,
        T6       = 4'd7,
        T7       = 4'd8,
        HALT     = 4'd9
    } state_e;

    typedef enum logic [3:0] {
        CLS_ALU  = 4'd0,
        CLS_IMM  = 4'd1,
        CLS_LD   = 4'd2,
        CLS_LDI  = 4'd3,
        CLS_ST   = 4'd4,
        CLS_BR   = 4'd5,
        CLS_JR   = 4'd6,
        CLS_NOP  = 4'd7,
        CLS_HALT = 4'd8
    } instr_class_e;

    // Classes whose write-back happens in T5 and which therefore end there.
    function automatic logic ends_at_t5(input instr_class_e cls);
        return (cls == CLS_ALU) || (cls == CLS_IMM) || (cls == CLS_LDI);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: maps IR[31:27] to an instruction class and the
// ALU operation the class uses. Undefined opcodes decode as NOP.
// Ports: opcode (in, 5) ; instr_class (out, class enum) ; alu_op (out, 5).
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0]   opcode,
    output instr_class_e instr_class,
    output logic [4:0]   alu_op
);

    // Opcode to class / ALU code lookup
    always_comb begin
        instr_class = CLS_NOP;
        alu_op      = ALU_NONE;
        case (opcode)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR, OPC_SHL: begin
                instr_class = CLS_ALU;
                alu_op      = opcode;
            end
            OPC_ADDI: begin instr_class = CLS_IMM;  alu_op = ALU_ADD; end
            OPC_ANDI: begin instr_class = CLS_IMM;  alu_op = ALU_AND; end
            OPC_ORI:  begin instr_class = CLS_IMM;  alu_op = ALU_OR;  end
            OPC_LDI:  begin instr_class = CLS_LDI;  alu_op = ALU_ADD; end
            OPC_LD:   begin instr_class = CLS_LD;   alu_op = ALU_ADD; end
            OPC_ST:   begin instr_class = CLS_ST;   alu_op = ALU_ADD; end
            // Branch target is PC + C, so the branch also adds.
            OPC_BR:   begin instr_class = CLS_BR;   alu_op = ALU_ADD; end
            OPC_JR:   begin instr_class = CLS_JR;   alu_op = ALU_NONE; end
            OPC_HALT: begin instr_class = CLS_HALT; alu_op = ALU_NONE; end
            default:  begin instr_class = CLS_NOP;  alu_op = ALU_NONE; end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the single-bus CPU datapath. Runs fetch
// (T0-T2), decodes IR[31:27] in T3 and issues the per-state bus, register,
// ALU, memory and CON-FF strobes. Outputs decode the state register (plus
// CON_out in branch T6).
// Ports: Clock, Reset (sync, active-high), Stop, Mem_ready, IR[31:0], CON_out
// in; PCout Zlowout MDRout Cout BAout Rout MARin MDRin IRin Yin Zin PCin Rin
// Gra Grb Grc IncPC Read Write CON_in operation[4:0] Run out.
// Option: CTRL_MEM_WAIT_EN makes T1, ld T6 and st T7 hold until Mem_ready=1.
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stop,
    input  logic        Mem_ready,
    input  logic [31:0] IR,
    input  logic        CON_out,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Cout,
    output logic        BAout,
    output logic        Rout,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        PCin,
    output logic        Rin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        CON_in,
    output logic [4:0]  operation,
    output logic        Run
);

    state_e       state_r;
    state_e       next_state_s;
    state_e       end_state_s;
    instr_class_e instr_class_s;
    logic [4:0]   alu_op_s;
    logic         mem_hold_s;
    logic         unused_ir_s;

    ctrl_decode u_decode (
        .opcode      (IR[IR_OPC_HI:IR_OPC_LO]),
        .instr_class (instr_class_s),
        .alu_op      (alu_op_s)
    );

    // Register fields are decoded by the datapath through Gra/Grb/Grc.
    assign unused_ir_s = ^IR[IR_RA_HI:0];

`ifdef CTRL_MEM_WAIT_EN
    assign mem_hold_s = ~Mem_ready;
`else
    logic unused_mem_ready_s;
    assign mem_hold_s         = 1'b0;
    assign unused_mem_ready_s = Mem_ready;
`endif

    // Stop is only honoured on the edge that leaves an instruction's last state.
    assign end_state_s = Stop ? HALT : T0;

    // State register; reset wins over every transition
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= RESET_ST;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state selection
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            RESET_ST: next_state_s = T0;
            T0:       next_state_s = T1;
            T1:       next_state_s = mem_hold_s ? T1 : T2;
            T2:       next_state_s = T3;
            T3: begin
                case (instr_class_s)
                    CLS_JR, CLS_NOP: next_state_s = end_state_s;
                    CLS_HALT:        next_state_s = HALT;
                    default:         next_state_s = T4;
                endcase
            end
            T4:       next_state_s = T5;
            T5:       next_state_s = ends_at_t5(instr_class_s) ? end_state_s : T6;
            T6: begin
                if (instr_class_s == CLS_LD && mem_hold_s) begin
                    next_state_s = T6;
                end else if (instr_class_s == CLS_BR) begin
                    next_state_s = end_state_s;
                end else begin
                    next_state_s = T7;
                end
            end
            T7:       next_state_s = (instr_class_s == CLS_ST && mem_hold_s) ? T7 : end_state_s;
            HALT:     next_state_s = HALT;
            default:  next_state_s = RESET_ST;
        endcase
    end

    // Output decode of the current state
    always_comb begin
        PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Cout = 1'b0; BAout = 1'b0;
        Rout = 1'b0; MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
        Zin = 1'b0; PCin = 1'b0; Rin = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        IncPC = 1'b0; Read = 1'b0; Write = 1'b0; CON_in = 1'b0;
        operation = ALU_NONE;
        Run = 1'b1;
        case (state_r)
            T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            T2: begin MDRout = 1'b1; IRin = 1'b1; end
            T3: begin
                case (instr_class_s)
                    CLS_ALU, CLS_IMM:        begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    CLS_LD, CLS_LDI, CLS_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    CLS_BR:  begin Gra = 1'b1; Rout = 1'b1; CON_in = 1'b1; end
                    CLS_JR:  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    default: begin Gra = 1'b0; end
                endcase
            end
            T4: begin
                case (instr_class_s)
                    CLS_ALU: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = alu_op_s; end
                    CLS_IMM, CLS_LD, CLS_LDI, CLS_ST: begin
                        Cout = 1'b1; Zin = 1'b1; operation = alu_op_s;
                    end
                    CLS_BR:  begin PCout = 1'b1; Yin = 1'b1; end
                    default: begin Zin = 1'b0; end
                endcase
            end
            T5: begin
                case (instr_class_s)
                    CLS_ALU, CLS_IMM, CLS_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CLS_LD, CLS_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
                    CLS_BR:  begin Cout = 1'b1; Zin = 1'b1; operation = alu_op_s; end
                    default: begin Zin = 1'b0; end
                endcase
            end
            T6: begin
                case (instr_class_s)
                    CLS_LD: begin Read = 1'b1; MDRin = 1'b1; end
                    CLS_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    CLS_BR: begin
                        // Branch taken only when the CON-FF loaded in T3 is set.
                        if (CON_out) begin
                            Zlowout = 1'b1; PCin = 1'b1;
                        end else begin
                            Zlowout = 1'b0; PCin = 1'b0;
                        end
                    end
                    default: begin Read = 1'b0; end
                endcase
            end
            T7: begin
                case (instr_class_s)
                    CLS_LD:  begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CLS_ST:  begin Write = 1'b1; end
                    default: begin Write = 1'b0; end
                endcase
            end
            default: Run = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit. A reference model builds, from the
// instruction tables, the list of per-cycle output vectors an instruction must
// produce, together with the Mem_ready/Stop values to drive in each cycle.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Reset, Stop, Mem_ready, CON_out;
    logic [31:0] IR;
    logic PCout, Zlowout, MDRout, Cout, BAout, Rout, MARin, MDRin, IRin, Yin, Zin;
    logic PCin, Rin, Gra, Grb, Grc, IncPC, Read, Write, CON_in, Run;
    logic [4:0] operation;

    control_unit dut (
        .Clock(Clock), .Reset(Reset), .Stop(Stop), .Mem_ready(Mem_ready), .IR(IR),
        .CON_out(CON_out), .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout),
        .Cout(Cout), .BAout(BAout), .Rout(Rout), .MARin(MARin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .Zin(Zin), .PCin(PCin), .Rin(Rin), .Gra(Gra),
        .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write),
        .CON_in(CON_in), .operation(operation), .Run(Run)
    );

    always #5 Clock = ~Clock;

`ifdef CTRL_MEM_WAIT_EN
    localparam bit MEM_WAIT = 1'b1;
`else
    localparam bit MEM_WAIT = 1'b0;
`endif

    localparam logic [25:0] E_PCOUT = 26'h1 << 25;
    localparam logic [25:0] E_ZLOW  = 26'h1 << 24;
    localparam logic [25:0] E_MDROUT = 26'h1 << 23;
    localparam logic [25:0] E_COUT  = 26'h1 << 22;
    localparam logic [25:0] E_BAOUT = 26'h1 << 21;
    localparam logic [25:0] E_ROUT  = 26'h1 << 20;
    localparam logic [25:0] E_MARIN = 26'h1 << 19;
    localparam logic [25:0] E_MDRIN = 26'h1 << 18;
    localparam logic [25:0] E_IRIN  = 26'h1 << 17;
    localparam logic [25:0] E_YIN   = 26'h1 << 16;
    localparam logic [25:0] E_ZIN   = 26'h1 << 15;
    localparam logic [25:0] E_PCIN  = 26'h1 << 14;
    localparam logic [25:0] E_RIN   = 26'h1 << 13;
    localparam logic [25:0] E_GRA   = 26'h1 << 12;
    localparam logic [25:0] E_GRB   = 26'h1 << 11;
    localparam logic [25:0] E_GRC   = 26'h1 << 10;
    localparam logic [25:0] E_INCPC = 26'h1 << 9;
    localparam logic [25:0] E_READ  = 26'h1 << 8;
    localparam logic [25:0] E_WRITE = 26'h1 << 7;
    localparam logic [25:0] E_CONIN = 26'h1 << 6;
    localparam logic [25:0] E_RUN   = 26'h1;
    localparam logic [25:0] E_FETCH0 = E_PCOUT | E_MARIN | E_INCPC | E_ZIN | E_RUN;

    logic [25:0] obs_s;
    assign obs_s = {PCout, Zlowout, MDRout, Cout, BAout, Rout, MARin, MDRin, IRin,
                    Yin, Zin, PCin, Rin, Gra, Grb, Grc, IncPC, Read, Write, CON_in,
                    operation, Run};

    typedef struct packed {
        logic [25:0] vec;
        logic        mem_ready;
        logic        stop;
    } entry_t;

    entry_t exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [25:0] opf(input logic [4:0] c);
        return {20'd0, c, 1'b0};
    endfunction

    // One expected cycle (or several when a memory state waits).
    task automatic push(input logic [25:0] v, input bit waitable, input int w);
        entry_t e;
        e.vec       = v | E_RUN;
        e.stop      = 1'($urandom_range(0, 1));
        e.mem_ready = 1'($urandom_range(0, 1));
        if (waitable && MEM_WAIT) begin
            for (int i = 0; i < w; i++) begin
                e.mem_ready = 1'b0;
                exp_q.push_back(e);
                e.stop = 1'($urandom_range(0, 1));
            end
            e.mem_ready = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    // Reference sequence of an instruction from T0 to its last state.
    task automatic build_seq(input logic [4:0] opc, input logic con, input logic stop_end,
                             input int wf, input int wm);
        entry_t last;
        logic [4:0] ic;
        exp_q.delete();
        push(E_PCOUT | E_MARIN | E_INCPC | E_ZIN, 1'b0, 0);
        push(E_ZLOW | E_PCIN | E_READ | E_MDRIN, 1'b1, wf);
        push(E_MDROUT | E_IRIN, 1'b0, 0);
        ic = (opc == 5'd12) ? 5'd3 : (opc == 5'd13) ? 5'd5 : 5'd6;
        case (opc)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8: begin
                push(E_GRB | E_ROUT | E_YIN, 1'b0, 0);
                push(E_GRC | E_ROUT | E_ZIN | opf(opc), 1'b0, 0);
                push(E_ZLOW | E_GRA | E_RIN, 1'b0, 0);
            end
            5'd12, 5'd13, 5'd14: begin
                push(E_GRB | E_ROUT | E_YIN, 1'b0, 0);
                push(E_COUT | E_ZIN | opf(ic), 1'b0, 0);
                push(E_ZLOW | E_GRA | E_RIN, 1'b0, 0);
            end
            5'd1, 5'd0, 5'd2: begin
                push(E_GRB | E_BAOUT | E_YIN, 1'b0, 0);
                push(E_COUT | E_ZIN | opf(5'd3), 1'b0, 0);
                if (opc == 5'd1) begin
                    push(E_ZLOW | E_GRA | E_RIN, 1'b0, 0);
                end else if (opc == 5'd0) begin
                    push(E_ZLOW | E_MARIN, 1'b0, 0);
                    push(E_READ | E_MDRIN, 1'b1, wm);
                    push(E_MDROUT | E_GRA | E_RIN, 1'b0, 0);
                end else begin
                    push(E_ZLOW | E_MARIN, 1'b0, 0);
                    push(E_GRA | E_ROUT | E_MDRIN, 1'b0, 0);
                    push(E_WRITE, 1'b1, wm);
                end
            end
            5'd18: begin
                push(E_GRA | E_ROUT | E_CONIN, 1'b0, 0);
                push(E_PCOUT | E_YIN, 1'b0, 0);
                push(E_COUT | E_ZIN | opf(5'd3), 1'b0, 0);
                push(con ? (E_ZLOW | E_PCIN) : 26'd0, 1'b0, 0);
            end
            5'd19:   push(E_GRA | E_ROUT | E_PCIN, 1'b0, 0);
            default: push(26'd0, 1'b0, 0);
        endcase
        last = exp_q.pop_back();
        last.stop = stop_end;
        exp_q.push_back(last);
    endtask

    task automatic test_reset();
        Reset = 1'b1; Stop = 1'b0; Mem_ready = 1'b0; CON_out = 1'b0; IR = 32'd0;
        for (int i = 0; i < 2; i++) begin
            @(posedge Clock); #1;
            checks++;
            if (obs_s !== 26'd0) begin
                errors++; $display("FAIL reset cyc %0d got %h want %h", i, obs_s, 26'd0);
            end
        end
        Reset = 1'b0;
        @(posedge Clock); #1;
        checks++;
        if (obs_s !== E_FETCH0) begin
            errors++; $display("FAIL reset_t0 got %h want %h", obs_s, E_FETCH0);
        end
    endtask

    task automatic test_alu();
        IR = 32'h1A920000; CON_out = 1'b0;
        build_seq(IR[31:27], 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            Mem_ready = exp_q[i].mem_ready; Stop = exp_q[i].stop; #1;
            checks++;
            if (obs_s !== exp_q[i].vec) begin
                errors++; $display("FAIL add cyc %0d got %h want %h", i, obs_s, exp_q[i].vec);
            end
            @(posedge Clock); #1;
        end
        checks++;
        if (obs_s !== E_FETCH0) begin
            errors++; $display("FAIL add_back_t0 got %h want %h", obs_s, E_FETCH0);
        end
    endtask

    task automatic test_branch();
        for (int c = 1; c >= 0; c--) begin
            IR = 32'h91800000; CON_out = 1'(c);
            build_seq(IR[31:27], 1'(c), 1'b0, 0, 0);
            for (int i = 0; i < exp_q.size(); i++) begin
                Mem_ready = exp_q[i].mem_ready; Stop = exp_q[i].stop; #1;
                checks++;
                if (obs_s !== exp_q[i].vec) begin
                    errors++;
                    $display("FAIL br con=%0d cyc %0d got %h want %h", c, i, obs_s, exp_q[i].vec);
                end
                @(posedge Clock); #1;
            end
            checks++;
            if (obs_s !== E_FETCH0) begin
                errors++; $display("FAIL br_back_t0 got %h want %h", obs_s, E_FETCH0);
            end
        end
    endtask

    task automatic test_mem_wait();
        for (int k = 0; k < 2; k++) begin
            IR = (k == 0) ? 32'h00800000 : 32'h11000000;
            build_seq(IR[31:27], 1'b0, 1'b0, 2, 3 - k);
            for (int i = 0; i < exp_q.size(); i++) begin
                Mem_ready = exp_q[i].mem_ready; Stop = exp_q[i].stop; #1;
                checks++;
                if (obs_s !== exp_q[i].vec) begin
                    errors++;
                    $display("FAIL memwait op=%0d cyc %0d got %h want %h", k, i, obs_s, exp_q[i].vec);
                end
                @(posedge Clock); #1;
            end
        end
    endtask

    task automatic test_stop_halt();
        for (int k = 0; k < 2; k++) begin
            IR = (k == 0) ? 32'h1A920000 : {5'd27, 27'h2A5};
            build_seq(IR[31:27], 1'b0, 1'b1, 0, 0);
            for (int i = 0; i < exp_q.size(); i++) begin
                Mem_ready = exp_q[i].mem_ready; Stop = exp_q[i].stop;
                if (k == 0 && i == 4) Stop = 1'b1;
                #1;
                checks++;
                if (obs_s !== exp_q[i].vec) begin
                    errors++;
                    $display("FAIL halt%0d cyc %0d got %h want %h", k, i, obs_s, exp_q[i].vec);
                end
                @(posedge Clock); #1;
            end
            for (int i = 0; i < 3; i++) begin
                Stop = 1'($urandom_range(0, 1)); Mem_ready = 1'($urandom_range(0, 1)); #1;
                checks++;
                if (obs_s !== 26'd0) begin
                    errors++; $display("FAIL halted%0d cyc %0d got %h want %h", k, i, obs_s, 26'd0);
                end
                @(posedge Clock); #1;
            end
            Reset = 1'b1; Stop = 1'b0;
            @(posedge Clock); #1;
            Reset = 1'b0;
            @(posedge Clock); #1;
            checks++;
            if (obs_s !== E_FETCH0) begin
                errors++; $display("FAIL halt_recover%0d got %h want %h", k, obs_s, E_FETCH0);
            end
        end
    endtask

    task automatic test_reset_abort();
        IR = 32'h10880000;
        build_seq(IR[31:27], 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            Mem_ready = exp_q[i].mem_ready; Stop = exp_q[i].stop; #1;
            checks++;
            if (obs_s !== exp_q[i].vec) begin
                errors++; $display("FAIL st_abort cyc %0d got %h want %h", i, obs_s, exp_q[i].vec);
            end
            if (i == 6) Reset = 1'b1;
            @(posedge Clock); #1;
        end
        checks++;
        if (obs_s !== 26'd0) begin
            errors++; $display("FAIL abort_reset got %h want %h", obs_s, 26'd0);
        end
        Reset = 1'b0;
        @(posedge Clock); #1;
        checks++;
        if (obs_s !== E_FETCH0) begin
            errors++; $display("FAIL abort_t0 got %h want %h", obs_s, E_FETCH0);
        end
    endtask

    task automatic test_random();
        logic [4:0] pool [15] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                                  5'd8, 5'd12, 5'd13, 5'd14, 5'd18, 5'd19, 5'd26};
        logic [4:0] opc;
        logic       con;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) opc = 5'($urandom);
            else opc = pool[$urandom_range(0, 14)];
            if (opc == 5'd27) opc = 5'd26;
            con = 1'($urandom_range(0, 1));
            IR = {opc, 27'($urandom)}; CON_out = con;
            build_seq(opc, con, 1'b0, $urandom_range(0, 3), $urandom_range(0, 3));
            for (int i = 0; i < exp_q.size(); i++) begin
                Mem_ready = exp_q[i].mem_ready; Stop = exp_q[i].stop; #1;
                checks++;
                if (obs_s !== exp_q[i].vec) begin
                    errors++;
                    $display("FAIL rand op=%b cyc %0d got %h want %h", opc, i, obs_s, exp_q[i].vec);
                end
                @(posedge Clock); #1;
            end
        end
        checks++;
        if (obs_s !== E_FETCH0) begin
            errors++; $display("FAIL rand_end_t0 got %h want %h", obs_s, E_FETCH0);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_mem_wait();
        test_stop_halt();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
